// File: rtl/q_fixed_pkg.sv
// Shared fixed-point helpers for the Q-update datapath: the 1.0 constant, the rounding
// constant, round-half-up rescaling and signed range checks/saturation on a wide carrier type.
package q_fixed_pkg;

    localparam int LW = 128;
    typedef logic signed [LW-1:0] wide_t;

    function automatic wide_t one_const(input int frac);
        return wide_t'(1) <<< frac;
    endfunction

    function automatic wide_t rnd_const(input int frac);
        return wide_t'(1) <<< (frac - 1);
    endfunction

    function automatic wide_t round_shift(input wide_t p, input int frac);
        return (p + rnd_const(frac)) >>> frac;
    endfunction

    function automatic logic in_range(input wide_t v, input int width);
        wide_t lim;
        lim = wide_t'(1) <<< (width - 1);
        return (v >= -lim) && (v < lim);
    endfunction

    function automatic wide_t saturate(input wide_t v, input int width);
        wide_t lim;
        lim = wide_t'(1) <<< (width - 1);
        if (v >= lim) begin
            return lim - wide_t'(1);
        end
        if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/q_max_tree.sv
// Combinational signed maximum over NUM_ACTIONS packed words; the lowest index wins a tie.
module q_max_tree #(
    parameter int WIDTH       = 32,
    parameter int NUM_ACTIONS = 4
) (
    input  logic [NUM_ACTIONS*WIDTH-1:0] i_q,
    output logic signed [WIDTH-1:0]      o_max
);

    always_comb begin
        o_max = $signed(i_q[WIDTH-1:0]);
        // Strict compare keeps the earlier action when values are equal.
        for (int k = 1; k < NUM_ACTIONS; k++) begin
            if ($signed(i_q[k*WIDTH +: WIDTH]) > o_max) begin
                o_max = $signed(i_q[k*WIDTH +: WIDTH]);
            end
        end
    end

endmodule

// File: rtl/q_update_pipe.sv
// Four-stage Q-learning update: q_new = (1-alpha)*q_old + alpha*(reward + gamma*max q_next).
// Define Q_UPDATE_SAT_EN to clamp overflowing intermediate points instead of wrapping them.
module q_update_pipe
    import q_fixed_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int FRAC        = 16,
    parameter int NUM_ACTIONS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             q_old,
    input  logic [WIDTH-1:0]             reward,
    input  logic [NUM_ACTIONS*WIDTH-1:0] q_next,
    input  logic [WIDTH-1:0]             alpha,
    input  logic [WIDTH-1:0]             gamma,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             q_new,
    output logic                         ovf,
    output logic [15:0]                  upd_count
);

`ifdef Q_UPDATE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [WIDTH:0] ONE_W = (WIDTH+1)'(one_const(FRAC));

    // Truncation to WIDTH at the register boundary provides the wrap behaviour.
    function automatic wide_t fix(input wide_t v);
        return SAT ? saturate(v, WIDTH) : v;
    endfunction

    logic                    r_v1, r_v2, r_v3, r_v4;
    logic signed [WIDTH-1:0] r_q1, r_r1, r_m1, r_q2, r_s2, r_p3, r_n3, r_q4;
    logic [WIDTH-1:0]        r_a1, r_g1, r_a2;
    logic                    r_o2, r_o3, r_o4;
    logic [15:0]             r_cnt;

    logic signed [WIDTH-1:0] w_max;
    logic signed [WIDTH:0]   w_oma;
    wide_t                   w_gm, w_s2, w_p3, w_n3, w_s4;
    logic                    w_adv;

    q_max_tree #(
        .WIDTH      (WIDTH),
        .NUM_ACTIONS(NUM_ACTIONS)
    ) u_max (
        .i_q  (q_next),
        .o_max(w_max)
    );

    always_comb begin
        w_gm  = round_shift(wide_t'($signed({1'b0, r_g1})) * wide_t'(r_m1), FRAC);
        w_s2  = wide_t'(r_r1) + w_gm;
        w_p3  = round_shift(wide_t'($signed({1'b0, r_a2})) * wide_t'(r_s2), FRAC);
        w_oma = ONE_W - {1'b0, r_a2};
        w_n3  = round_shift(wide_t'(w_oma) * wide_t'(r_q2), FRAC);
        w_s4  = wide_t'(r_p3) + wide_t'(r_n3);
    end

    // Whole pipe freezes only when a finished result is waiting on downstream.
    assign w_adv     = out_ready | ~r_v4;
    assign in_ready  = w_adv;
    assign out_valid = r_v4;
    assign q_new     = r_q4;
    assign ovf       = r_o4;
    assign upd_count = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0; r_v4 <= 1'b0;
            r_q1 <= '0; r_r1 <= '0; r_m1 <= '0; r_a1 <= '0; r_g1 <= '0;
            r_q2 <= '0; r_a2 <= '0; r_s2 <= '0; r_o2 <= 1'b0;
            r_p3 <= '0; r_n3 <= '0; r_o3 <= 1'b0;
            r_q4 <= '0; r_o4 <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_adv) begin
                r_v1 <= in_valid;
                r_q1 <= q_old;
                r_r1 <= reward;
                r_m1 <= w_max;
                r_a1 <= alpha;
                r_g1 <= gamma;

                r_v2 <= r_v1;
                r_q2 <= r_q1;
                r_a2 <= r_a1;
                r_s2 <= WIDTH'(fix(w_s2));
                r_o2 <= !in_range(w_s2, WIDTH);

                r_v3 <= r_v2;
                r_p3 <= WIDTH'(fix(w_p3));
                r_n3 <= WIDTH'(fix(w_n3));
                r_o3 <= r_o2 | !in_range(w_p3, WIDTH) | !in_range(w_n3, WIDTH);

                r_v4 <= r_v3;
                r_q4 <= WIDTH'(fix(w_s4));
                r_o4 <= r_o3 | !in_range(w_s4, WIDTH);
            end
            if (r_v4 && out_ready) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_q_update_pipe.sv
// Bench for q_update_pipe: fixed vectors, backpressure, mid-flight reset and random traffic
// checked against an arithmetic reference model through an expected-result queue.
`timescale 1ns/1ps
module tb_q_update_pipe;

    localparam int W  = 32;
    localparam int F  = 16;
    localparam int NA = 4;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -MAXV - 64'sd1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid, in_ready, out_valid, out_ready, ovf;
    logic [W-1:0]    q_old, reward, alpha, gamma, q_new;
    logic [NA*W-1:0] q_next;
    logic [15:0]     upd_count;

    int   n_checks = 0;
    int   n_err    = 0;
    int   acc_cnt  = 0;
    int   hs_cnt   = 0;
    bit   sb_en    = 1'b0;
    bit   ord_run  = 1'b0;
    logic [W:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    q_update_pipe #(.WIDTH(W), .FRAC(F), .NUM_ACTIONS(NA)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .q_old(q_old), .reward(reward), .q_next(q_next), .alpha(alpha), .gamma(gamma),
        .out_valid(out_valid), .out_ready(out_ready), .q_new(q_new), .ovf(ovf),
        .upd_count(upd_count)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // reference model: plain integer arithmetic on the update equation
    function automatic longint rnd(input longint p);
        return (p + 64'sd32768) >>> F;
    endfunction

    function automatic longint fit(input longint v, output bit o);
        o = (v > MAXV) || (v < MINV);
`ifdef Q_UPDATE_SAT_EN
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
`else
        return longint'(int'(v));
`endif
    endfunction

    function automatic logic [W:0] model(input logic [W-1:0] qo, input logic [W-1:0] rw,
                                         input logic [NA*W-1:0] qn, input logic [W-1:0] al,
                                         input logic [W-1:0] ga);
        longint mx, s, a, b, t;
        bit o, ov;
        logic [W-1:0] word;
        word = qn[W-1:0];
        mx = longint'($signed(word));
        for (int k = 1; k < NA; k++) begin
            word = qn[k*W +: W];
            if (longint'($signed(word)) > mx) mx = longint'($signed(word));
        end
        s  = fit(longint'($signed(rw)) + rnd(longint'(ga) * mx), o);
        ov = o;
        a  = fit(rnd(longint'(al) * s), o);
        ov = ov | o;
        b  = fit(rnd(((64'sd1 <<< F) - longint'(al)) * longint'($signed(qo))), o);
        ov = ov | o;
        t  = fit(a + b, o);
        ov = ov | o;
        return {ov, t[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rword();
        logic [W-1:0] v;
        v = $urandom();
        if ($urandom_range(0, 1) == 0) v = {{13{v[18]}}, v[18:0]};
        return v;
    endfunction

    // driver tasks
    task automatic send(input logic [W-1:0] qo, input logic [W-1:0] rw, input logic [NA*W-1:0] qn,
                        input logic [W-1:0] al, input logic [W-1:0] ga);
        int waitc = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; q_old = qo; reward = rw; q_next = qn; alpha = al; gamma = ga;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(qo, rw, qn, al, ga));
                acc_cnt++;
                break;
            end
            waitc++;
            if (waitc > 200) begin
                check("accept_timeout", in_ready, 1);
                break;
            end
        end
    endtask

    task automatic send_rand();
        send(rword(), rword(), {rword(), rword(), rword(), rword()},
             W'($urandom_range(0, 65536)), W'($urandom_range(0, 65536)));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int limit);
        int c = 0;
        while (exp_q.size() != 0 && c < limit) begin
            @(negedge clk);
            c++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // scoreboard: in-order compare, stall-hold and stale-result detection
    logic [W-1:0] prev_q;
    logic         prev_o;
    bit           prev_stall = 1'b0;
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst) begin
            hs_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            if (sb_en && prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_q", q_new, prev_q);
                check("hold_ovf", ovf, prev_o);
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        check("stale_result", out_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_q", q_new, e[W-1:0]);
                        check("sb_ovf", ovf, e[W]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_q = q_new;
            prev_o = ovf;
        end
    end

    typedef struct {
        logic [W-1:0]    qo, rw;
        logic [NA*W-1:0] qn;
        logic [W-1:0]    al, ga, eq;
        logic            eo;
    } vec_t;
    localparam int NV = 8;
    vec_t vt[NV];

    initial begin
        in_valid = 1'b0; q_old = '0; reward = '0; q_next = '0; alpha = '0; gamma = '0;
        out_ready = 1'b1;

        vt[0] = '{32'h0, 32'h00010000, {32'h0, 32'h00008000, 32'h0, 32'h0},
                  32'h8000, 32'hE666, 32'h0000B99A, 1'b0};
        vt[1] = '{32'h0, 32'h0, {32'hFFFF0000, 32'hFFFE0000, 32'hFFFF8000, 32'hFFFF0000},
                  32'h10000, 32'h10000, 32'hFFFF8000, 1'b0};
`ifdef Q_UPDATE_SAT_EN
        vt[2] = '{32'h0, 32'h7FFF0000, {32'h0, 32'h0, 32'h0, 32'h7FFF0000},
                  32'h10000, 32'h10000, 32'h7FFFFFFF, 1'b1};
        vt[6] = '{32'h0, 32'h80000000, {4{32'h80000000}},
                  32'h10000, 32'h10000, 32'h80000000, 1'b1};
`else
        vt[2] = '{32'h0, 32'h7FFF0000, {32'h0, 32'h0, 32'h0, 32'h7FFF0000},
                  32'h10000, 32'h10000, 32'hFFFE0000, 1'b1};
        vt[6] = '{32'h0, 32'h80000000, {4{32'h80000000}},
                  32'h10000, 32'h10000, 32'h00000000, 1'b1};
`endif
        vt[3] = '{32'h00010000, 32'h0, {4{32'h00020000}}, 32'h8000, 32'h8000, 32'h00010000, 1'b0};
        vt[4] = '{32'h00000003, 32'h0, {4{32'h0}}, 32'h8000, 32'h0, 32'h00000002, 1'b0};
        vt[5] = '{32'hFFFFFFFD, 32'h0, {4{32'h0}}, 32'h8000, 32'h0, 32'hFFFFFFFF, 1'b0};
        vt[7] = '{32'h12345678, 32'h7FFFFFFF, {4{32'h0}}, 32'h0, 32'h10000, 32'h12345678, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_q_new", q_new, 0);
        check("rst_ovf", ovf, 0);
        check("rst_upd_count", upd_count, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // fixed vectors with exact latency
        sb_en = 1'b0;
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; q_old = vt[i].qo; reward = vt[i].rw; q_next = vt[i].qn;
            alpha = vt[i].al; gamma = vt[i].ga;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                if (c < 4) begin
                    check($sformatf("vec%0d_early_valid_c%0d", i, c), out_valid, 0);
                end else begin
                    check($sformatf("vec%0d_out_valid", i), out_valid, 1);
                    check($sformatf("vec%0d_q_new", i), q_new, vt[i].eq);
                    check($sformatf("vec%0d_ovf", i), ovf, vt[i].eo);
                end
            end
        end

        // backpressure: six beats with downstream blocked
        do_reset();
        sb_en = 1'b1; acc_cnt = 0; out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand();
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                repeat (10) @(negedge clk);
                check("bp_accepted", acc_cnt, 4);
                check("bp_in_ready", in_ready, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain(100);
        check("bp_upd_count", upd_count, 6);
        check("bp_handshakes", hs_cnt, 6);

        // reset with three beats in flight
        for (int i = 0; i < 3; i++) send_rand();
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mr_out_valid", out_valid, 0);
        check("mr_upd_count", upd_count, 0);
        check("mr_q_new", q_new, 0);
        check("mr_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mr_no_stale", hs_cnt, 0);
        check("mr_upd_after", upd_count, 0);

        // random traffic with random backpressure
        do_reset();
        acc_cnt = 0; ord_run = 1'b1;
        fork
            begin
                while (ord_run) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk); #1;
                        in_valid = 1'b0;
                    end
                    send_rand();
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
                drain(3000);
                ord_run = 1'b0;
            end
        join
        check("rand_upd_count", upd_count, 300);
        check("rand_handshakes", hs_cnt, 300);

        // final report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
